// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and constants for the 4-phase req/ack clock-crossing blocks
//   hs_state_t          : receive/send handshake FSM state encoding
//   sync_stages_default : default synchroniser depth, common to both sides
package cdc_hs_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACK  = 2'b01
   } hs_state_t;
   localparam int sync_stages_default = 2;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: N-flop single-bit synchroniser, reset to 0
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input bit
//   q   : synchronised output (last flop of the chain)
module cdc_sync_bit #(
   parameter int stages = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [stages-1:0] ff;
   always_ff @(posedge clk)
      if (rst) ff <= '0;
      else     ff <= {ff[stages-2:0], d};
   assign q = ff[stages-1];
endmodule

// File: rtl/cdc_4phase_rx.sv
// cdc_4phase_rx: receive endpoint of a 4-phase req/ack bundled-data handshake
//   o_clk, o_rst : destination clock and synchronous active-high reset
//   i_req        : asynchronous request from sender
//   i_data       : bundled data, stable while i_req is high and unacked
//   o_ack        : registered acknowledge back to sender
//   o_data       : FIFO head word (show-ahead)
//   o_valid      : FIFO non-empty
//   i_ready      : downstream accepts head word when o_valid & i_ready
//   o_level      : FIFO occupancy
module cdc_4phase_rx
   import cdc_hs_pkg::*;
#(
   parameter int data_width  = 8,
   parameter int sync_stages = sync_stages_default,
   parameter int fifo_depth  = 2
) (
   input  logic                          o_clk,
   input  logic                          o_rst,
   input  logic                          i_req,
   input  logic [data_width-1:0]         i_data,
   output logic                          o_ack,
   output logic [data_width-1:0]         o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(fifo_depth):0]   o_level
);
   localparam int aw = $clog2(fifo_depth);
   localparam int lw = aw + 1;

   logic                  req_s;
   hs_state_t             state, state_n;
   logic                  wr, rd, full;
   logic [aw-1:0]         wptr, rptr;
   logic [data_width-1:0] mem [fifo_depth];

   cdc_sync_bit #(.stages(sync_stages)) u_req_sync (
      .clk (o_clk),
      .rst (o_rst),
      .d   (i_req),
      .q   (req_s)
   );

   assign full    = o_level == lw'(fifo_depth);
   assign o_valid = o_level != '0;
   assign rd      = o_valid & i_ready;
   assign o_data  = mem[rptr];

   // Capture only on the IDLE->ACK edge, so one word per req pulse; full is
   // taken from the start of the cycle, a same-cycle read does not unblock it.
   always_comb begin
      wr      = 1'b0;
      state_n = IDLE;
      wr      = (state == IDLE) & req_s & ~full;
      state_n = (state == IDLE) ? (wr ? ACK : IDLE) :
                (state == ACK)  ? (req_s ? ACK : IDLE) : IDLE;
   end

   // o_ack is registered from the next state so it tracks state==ACK glitch-free.
   always_ff @(posedge o_clk)
      if (o_rst) begin
         state <= IDLE;
         o_ack <= 1'b0;
      end else begin
         state <= state_n;
         o_ack <= state_n == ACK;
      end

   always_ff @(posedge o_clk)
      if (o_rst) begin
         wptr    <= '0;
         rptr    <= '0;
         o_level <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         o_level <= o_level + lw'(wr) - lw'(rd);
      end

   always_ff @(posedge o_clk)
      if (wr) mem[wptr] <= i_data;
endmodule
